// File: rtl/lab04_abs_adder_seq.sv
// lab04_abs_adder_seq: bit-serial |a| + b (mode=0) or |a| + |b| (mode=1).
// Operands are captured on acceptance. A single full adder then consumes
// one bit per clock, LSB first. Absolute values are formed on the fly with
// a serial two's-complement negate: invert each bit and add an incoming
// carry that starts at 1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side is ready only in IDLE. The output side is valid
// only in DONE. The producer may change its data freely while ready is low.
module lab04_abs_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SW = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_na;
  logic             r_nb;
  logic [SW-1:0]    r_shift;   // sum bits 0..WIDTH-2, newest bit at the MSB end
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_a_i;
  logic w_b_i;
  logic w_x;
  logic w_y;
  logic w_neg_b;
  logic w_s;
  logic w_c_next;
  logic w_na_next;
  logic w_nb_next;
  logic w_last;

  // Current operand bits and the serial negate / full-adder datapath
  always_comb begin
    w_a_i     = r_a[r_cnt];
    w_b_i     = r_b[r_cnt];
    w_neg_b   = r_mode & r_b[WIDTH-1];
    w_x       = r_a[WIDTH-1] ? (~w_a_i ^ r_na) : w_a_i;
    w_y       = w_neg_b ? (~w_b_i ^ r_nb) : w_b_i;
    w_na_next = ~w_a_i & r_na;
    w_nb_next = ~w_b_i & r_nb;
    w_s       = w_x ^ w_y ^ r_c;
    w_c_next  = (w_x & w_y) | ((w_x ^ w_y) & r_c);
    w_last    = (r_state == S_CALC) && (r_cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are a pure function of the state
  always_comb begin
    in_ready    = (r_state == S_IDLE);
    busy        = (r_state == S_CALC);
    out_valid   = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  // Operand capture, serial computation and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_na    <= 1'b0;
      r_nb    <= 1'b0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_na   <= 1'b1;
            r_nb   <= 1'b1;
          end
        end
        S_CALC: begin
          r_cnt   <= r_cnt + CW'(1);
          r_c     <= w_c_next;
          r_na    <= w_na_next;
          r_nb    <= w_nb_next;
          r_shift <= SW'({w_s, r_shift} >> 1);
          // The visible result changes only when the last bit is produced
          if (w_last) begin
            r_sum  <= {w_s, r_shift};
            r_cout <= w_c_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_lab04_abs_adder_seq.sv
// Bench for lab04_abs_adder_seq: directed cases, random operations, DONE
// hold, back-to-back traffic and a reset abort. It uses an 8-bit instance
// and a 4-bit instance.
module tb_lab04_abs_adder_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit DUT signals
  logic       in_valid, in_ready, mode, out_valid, out_ready, c_out, busy;
  logic [7:0] a, b, sum;
  logic [1:0] dbg_state;

  // 4-bit DUT signals
  logic       in_valid4, in_ready4, mode4, out_valid4, out_ready4, c_out4, busy4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] dbg_state4;

  lab04_abs_adder_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy), .o_dbg_state(dbg_state)
  );

  lab04_abs_adder_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .busy(busy4), .o_dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] prev_res;   // last delivered {c_out, sum}, expected to be held
  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference: plain integer arithmetic on absolute values
  function automatic logic [8:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mm);
    int abs_a, val_b, s;
    abs_a = ma[7] ? (256 - int'(ma)) : int'(ma);
    val_b = (mm && mb[7]) ? (256 - int'(mb)) : int'(mb);
    s = abs_a + val_b;
    return s[8:0];
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] ma, input logic [3:0] mb,
                                        input logic mm);
    int abs_a, val_b, s;
    abs_a = ma[3] ? (16 - int'(ma)) : int'(ma);
    val_b = (mm && mb[3]) ? (16 - int'(mb)) : int'(mb);
    s = abs_a + val_b;
    return s[4:0];
  endfunction

  // ---------------- driver: one full 8-bit operation ----------------
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_m, input int hold_cycles);
    logic [8:0] exp;
    int edges;
    int waitc;
    exp_q.push_back(model8(op_a, op_b, op_m));
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    assert_cnt++;
    if (in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL in_ready_wait: got %b want 1", in_ready);
    end
    a = op_a; b = op_b; mode = op_m; in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
    while (!out_valid && edges < 40) begin
      assert_cnt++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || {c_out, sum} !== prev_res) begin
        fail_cnt++;
        $display("FAIL calc_status: busy=%b in_ready=%b res=%h want busy=1 in_ready=0 res=%h",
                 busy, in_ready, {c_out, sum}, prev_res);
      end
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    assert_cnt++;
    if (out_valid !== 1'b1 || edges != 9) begin
      fail_cnt++;
      $display("FAIL latency: out_valid=%b edges=%0d want out_valid=1 edges=9", out_valid, edges);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
    end
    exp = exp_q.pop_front();
    assert_cnt++;
    if (out_valid !== 1'b1 || {c_out, sum} !== exp) begin
      fail_cnt++;
      $display("FAIL result a=%h b=%h m=%b: got valid=%b c=%b sum=%h want c=%b sum=%h",
               op_a, op_b, op_m, out_valid, c_out, sum, exp[8], exp[7:0]);
    end
    prev_res = exp;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    assert_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL consume: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; mode = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; mode4 = 0;
    #2;
    assert_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: ov=%b busy=%b sum=%h c=%b want 0/0/00/0",
               out_valid, busy, sum, c_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_ready: in_ready=%b in_ready4=%b want 1/1", in_ready, in_ready4);
    end
    prev_res = 9'h000;
  endtask

  task automatic test_directed();
    run_op(8'hF6, 8'h05, 1'b0, 0);   // 10 + 5
    run_op(8'h80, 8'h80, 1'b0, 1);   // 128 + 128 wraps with carry
    run_op(8'hFD, 8'hFB, 1'b1, 0);   // 3 + 5
    run_op(8'hFD, 8'hFB, 1'b0, 2);   // 3 + 251
    run_op(8'h80, 8'h80, 1'b1, 0);   // 128 + 128 in abs mode
    run_op(8'h00, 8'h00, 1'b0, 0);
  endtask

  task automatic test_width4();
    logic [4:0] exp;
    int edges;
    exp = model4(4'h9, 4'h3, 1'b0);
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h3; mode4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid4 = 1'b0; a4 = 4'hF; b4 = 4'hF; mode4 = 1'b1;
    while (!out_valid4 && edges < 30) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    assert_cnt++;
    if (out_valid4 !== 1'b1 || edges != 5) begin
      fail_cnt++;
      $display("FAIL w4_latency: out_valid=%b edges=%0d want 1/5", out_valid4, edges);
    end
    assert_cnt++;
    if ({c_out4, sum4} !== exp) begin
      fail_cnt++;
      $display("FAIL w4_result: got c=%b sum=%h want c=%b sum=%h", c_out4, sum4, exp[4], exp[3:0]);
    end
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    assert_cnt++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL w4_consume: in_ready=%b out_valid=%b want 1/0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      run_op(8'($urandom_range(128, 255)), 8'($urandom), 1'($urandom), 0);
    end
  endtask

  task automatic test_hold_done();
    logic [8:0] exp;
    int edges;
    exp = model8(8'hC3, 8'h9A, 1'b1);
    @(negedge clk);
    a = 8'hC3; b = 8'h9A; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      a = ~a; b = b + 8'd1; mode = ~mode;   // in_valid stays high throughout
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
      assert_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {c_out, sum} !== exp) begin
        fail_cnt++;
        $display("FAIL hold_done[%0d]: ov=%b ir=%b res=%h want 1/0/%h",
                 i, out_valid, in_ready, {c_out, sum}, exp);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    assert_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {c_out, sum} !== exp) begin
      fail_cnt++;
      $display("FAIL hold_release: ir=%b ov=%b res=%h want 1/0/%h", in_ready, out_valid,
               {c_out, sum}, exp);
    end
    prev_res = exp;
  endtask

  task automatic test_reset_mid_calc();
    int bad;
    run_op(8'h10, 8'h01, 1'b0, 0);     // leaves a nonzero result visible
    @(negedge clk);
    a = 8'h85; b = 8'h7F; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    assert_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0 ||
        in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL abort_clear: busy=%b ov=%b sum=%h c=%b ir=%b want 0/0/00/0/1",
               busy, out_valid, sum, c_out, in_ready);
    end
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    assert_cnt++;
    if (bad != 0) begin
      fail_cnt++;
      $display("FAIL abort_no_result: %0d cycles with activity, want 0", bad);
    end
    prev_res = 9'h000;
    run_op(8'h85, 8'h7F, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width4();
    test_hold_done();
    test_back_to_back();
    test_random();
    test_reset_mid_calc();
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
